mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 11, RAM word-address width.
REQ-002 The module SHALL have parameter DATA_W, default 32, RAM data width.
REQ-003 The module SHALL have parameter RD_LAT, default 1, RAM read latency in cycles (1..4).
REQ-004 The module SHALL have port clka  in  1  sole clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 The module SHALL have port i_req  in  1  instruction-fetch request, read-only, held until i_ack.
REQ-007 The module SHALL have port i_addr  in  ADDR_W  instruction fetch address.
REQ-008 The module SHALL have port i_ack  out  1  one-cycle completion pulse for the fetch port.
REQ-009 The module SHALL have port i_rdata  out  DATA_W  fetched word, valid while i_ack=1 and held after it.
REQ-010 The module SHALL have port d_req  in  1  data-port request, held until d_ack.
REQ-011 The module SHALL have port d_we  in  1  data-port write enable, 1=store, 0=load.
REQ-012 The module SHALL have port d_addr  in  ADDR_W  data-port address.
REQ-013 The module SHALL have port d_wdata  in  DATA_W  store data.
REQ-014 The module SHALL have port d_ack  out  1  one-cycle completion pulse for the data port.
REQ-015 The module SHALL have port d_rdata  out  DATA_W  load data, updated only on loads.
REQ-016 The module SHALL have port ram_wea  out  1  RAM write enable (drives wea[0]).
REQ-017 The module SHALL have ports ram_addra out ADDR_W, ram_dina out DATA_W, ram_douta in DATA_W to the single-port RAM.
REQ-018 The module SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT, ACK.
REQ-020 In IDLE with any request high, the arbiter SHALL grant one port, register its address/we/wdata onto ram_addra/ram_wea/ram_dina and go to ISSUE; with no request it SHALL stay in IDLE.
REQ-021 ram_wea SHALL be high only during ISSUE of a granted store, exactly one cycle per store.
REQ-022 ISSUE SHALL last one cycle, then WAIT SHALL last RD_LAT cycles under a down-counter, then ACK.
REQ-023 On entry to ACK the arbiter SHALL capture ram_douta into the granted port's rdata (loads and fetches only) and assert that port's ack for exactly the one ACK cycle; ACK SHALL go to IDLE.
REQ-024 Latency from the IDLE grant cycle T to ack high SHALL be T+2+RD_LAT (T+3 at default), for reads and writes alike.
REQ-025 Requests, addresses and data SHALL be sampled only in IDLE; changes in other states SHALL be ignored.
REQ-026 A requester keeping req high through ACK SHALL be treated as a new request in the following IDLE cycle.
REQ-027 i_ack and d_ack SHALL never be high in the same cycle; at most one access SHALL be outstanding.
REQ-028 ram_addra and ram_dina SHALL hold their last values outside ISSUE/WAIT.
REQ-029 Without MEM_ARB_RR_EN, when both requests are high in IDLE, the data port SHALL win.

Reset
REQ-030 While rst=1, the FSM SHALL be IDLE; ram_wea, i_ack, d_ack and busy SHALL be 0; ram_addra, ram_dina, i_rdata, d_rdata SHALL be 0; the RR pointer SHALL indicate "last granted = I".
REQ-031 Reset asserted mid-access SHALL abort it immediately (ram_wea forced 0 asynchronously), and no ack SHALL be issued for the aborted access.

Configuration
REQ-032 With macro MEM_ARB_RR_EN defined, ties SHALL go to the port not granted last, with a 1-bit last-grant pointer updated on each grant; a lone request SHALL always be granted.
REQ-033 Without MEM_ARB_RR_EN, the pointer SHALL not exist and fixed data priority SHALL apply; single-requester timing SHALL be identical in both builds.

Verification
REQ-034 A bench SHALL preload RAM[5]=0x12345678, then apply i_req with i_addr=5 -> i_ack is high 3 cycles after grant and i_rdata=0x12345678.
REQ-035 A bench SHALL apply a d_req store with addr=0x7FF and wdata=0xDEADBEEF followed by a load of 0x7FF -> ram_wea is high exactly 1 cycle, and the load returns d_rdata=0xDEADBEEF.
REQ-036 A bench SHALL hold i_req and d_req high together for 4 accesses -> without MEM_ARB_RR_EN the grant order is D,D,D,D; with it, the order is D,I,D,I.
REQ-037 A bench SHALL pulse rst during WAIT of a store -> no ack is issued, busy=0, and the FSM is in IDLE before the next edge.
REQ-038 A bench SHALL use RD_LAT=3 and a fetch -> i_ack is high at T+5, and busy stays high from T+1 to T+5.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Fetch port, data port and RAM-side bus of mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              ram_wea;
  logic [ADDR_W-1:0] ram_addra;
  logic [DATA_W-1:0] ram_dina;
  logic [DATA_W-1:0] ram_douta;

  logic              busy;

  // Requesters and the RAM model sit on the master side.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_douta,
    input  i_ack, i_rdata, d_ack, d_rdata, ram_wea, ram_addra, ram_dina, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_douta,
    output i_ack, i_rdata, d_ack, d_rdata, ram_wea, ram_addra, ram_dina, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (fetch/data) arbiter onto one single-port RAM.
//               Define MEM_ARB_RR_EN for round-robin tie breaking.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  wire logic     clka,
  input  wire logic     rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [1:0] c_WAIT_LOAD = 2'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_cnt;
  logic              r_gnt_d;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              w_gnt;
  logic              w_pick_d;

  assign w_gnt = bus.i_req | bus.d_req;

`ifdef MEM_ARB_RR_EN
  // Last-grant pointer: 1 = data port, 0 = fetch port.
  logic r_last_d;

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_last_d <= 1'b0;
    end else if (r_state == IDLE && w_gnt) begin
      r_last_d <= w_pick_d;
    end
  end

  assign w_pick_d = bus.d_req & (~bus.i_req | ~r_last_d);
`else
  assign w_pick_d = bus.d_req;
`endif

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    bus.ram_wea = 1'b0;
    bus.i_ack   = 1'b0;
    bus.d_ack   = 1'b0;
    bus.busy    = 1'b1;
    case (r_state)
      IDLE: begin
        bus.busy = 1'b0;
        if (w_gnt) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        bus.ram_wea = r_we;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (r_cnt == 2'd0) begin
          w_state_nxt = ACK;
        end
      end
      ACK: begin
        bus.i_ack   = ~r_gnt_d;
        bus.d_ack   = r_gnt_d;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request fields are latched only at grant; RAM-side buses then hold
  // until the next grant so the RAM sees a stable address through WAIT.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_cnt     <= 2'd0;
      r_gnt_d   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt) begin
            r_gnt_d <= w_pick_d;
            r_we    <= w_pick_d & bus.d_we;
            r_addr  <= w_pick_d ? bus.d_addr : bus.i_addr;
            if (w_pick_d) begin
              r_wdata <= bus.d_wdata;
            end
          end
        end
        ISSUE: begin
          r_cnt <= c_WAIT_LOAD;
        end
        WAIT: begin
          if (r_cnt == 2'd0) begin
            if (!r_we) begin
              if (r_gnt_d) begin
                r_d_rdata <= bus.ram_douta;
              end else begin
                r_i_rdata <= bus.ram_douta;
              end
            end
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ram_addra = r_addr;
  assign bus.ram_dina  = r_wdata;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_rdata   = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter (RD_LAT 1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic clka = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clka = ~clka;

  mem_arbiter_if #(.ADDR_W(11), .DATA_W(32)) b1 ();
  mem_arbiter_if #(.ADDR_W(11), .DATA_W(32)) b3 ();

  mem_arbiter #(.ADDR_W(11), .DATA_W(32), .RD_LAT(1)) dut1 (
    .clka (clka),
    .rst  (rst),
    .bus  (b1)
  );

  mem_arbiter #(.ADDR_W(11), .DATA_W(32), .RD_LAT(3)) dut3 (
    .clka (clka),
    .rst  (rst),
    .bus  (b3)
  );

  // RAM models: latency 1 for dut1, 3-stage pipeline for dut3.
  logic        pre_en;
  logic [10:0] pre_a;
  logic [31:0] pre_d;
  logic [31:0] mem1 [0:2047];
  logic [31:0] mem3 [0:2047];
  logic [31:0] rd1, p0, p1, p2;

  always @(posedge clka) begin
    if (pre_en)          mem1[pre_a] <= pre_d;
    else if (b1.ram_wea) mem1[b1.ram_addra] <= b1.ram_dina;
    rd1 <= mem1[b1.ram_addra];
  end

  always @(posedge clka) begin
    if (pre_en)          mem3[pre_a] <= pre_d;
    else if (b3.ram_wea) mem3[b3.ram_addra] <= b3.ram_dina;
    p0 <= mem3[b3.ram_addra];
    p1 <= p0;
    p2 <= p1;
  end

  assign b1.ram_douta = rd1;
  assign b3.ram_douta = p2;

  task automatic preload(input logic [10:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_a = a; pre_d = d;
    @(posedge clka); #1;
    pre_en = 1'b0;
  endtask

  // Stimulus only: one access on dut1, perturbing inputs after the grant.
  task automatic run_access(input logic is_d, input logic we, input logic [10:0] addr,
                            input logic [31:0] wdata, output int lat, output int wea_cnt,
                            output int both_cnt);
    lat = 0; wea_cnt = 0; both_cnt = 0;
    if (is_d) begin
      b1.d_req = 1'b1; b1.d_we = we; b1.d_addr = addr; b1.d_wdata = wdata;
    end else begin
      b1.i_req = 1'b1; b1.i_addr = addr;
    end
    for (int k = 1; k <= 12; k++) begin
      @(posedge clka); #1;
      if (k == 1) begin
        b1.i_addr = ~addr; b1.d_addr = ~addr; b1.d_wdata = ~wdata; b1.d_we = ~we;
      end
      if (b1.ram_wea) wea_cnt++;
      if (b1.i_ack && b1.d_ack) both_cnt++;
      if (is_d ? b1.d_ack : b1.i_ack) begin
        lat = k;
        break;
      end
    end
    b1.i_req = 1'b0; b1.d_req = 1'b0; b1.d_we = 1'b0;
    @(posedge clka); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clka);
    #1;
    n_chk++;
    if ({b1.busy, b1.i_ack, b1.d_ack, b1.ram_wea} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected 0000", {b1.busy, b1.i_ack, b1.d_ack, b1.ram_wea});
    end
    n_chk++;
    if (b1.ram_addra !== 11'd0 || b1.ram_dina !== 32'd0) begin
      n_fail++; $display("FAIL reset_ram_bus: got addr %h din %h expected 0 0", b1.ram_addra, b1.ram_dina);
    end
    n_chk++;
    if (b1.i_rdata !== 32'd0 || b1.d_rdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %h %h expected 0 0", b1.i_rdata, b1.d_rdata);
    end
    rst = 1'b0;
    @(posedge clka); #1;
    n_chk++;
    if (b1.busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_req: busy got %b expected 0", b1.busy);
    end
  endtask

  task automatic test_fetch;
    int lat, wea, both;
    run_access(1'b0, 1'b0, 11'd5, 32'd0, lat, wea, both);
    n_chk++;
    if (lat !== 3) begin n_fail++; $display("FAIL fetch_latency: got %0d expected 3", lat); end
    n_chk++;
    if (b1.i_rdata !== 32'h12345678) begin
      n_fail++; $display("FAIL fetch_rdata: got %h expected 12345678", b1.i_rdata);
    end
    n_chk++;
    if (wea !== 0 || both !== 0) begin
      n_fail++; $display("FAIL fetch_side: wea %0d both %0d expected 0 0", wea, both);
    end
    n_chk++;
    if (b1.ram_addra !== 11'd5 || b1.busy !== 1'b0) begin
      n_fail++; $display("FAIL fetch_hold: addr %h busy %b expected 005 0", b1.ram_addra, b1.busy);
    end
  endtask

  task automatic test_store_load;
    int lat, wea, both;
    run_access(1'b1, 1'b1, 11'h7FF, 32'hDEADBEEF, lat, wea, both);
    n_chk++;
    if (lat !== 3) begin n_fail++; $display("FAIL store_latency: got %0d expected 3", lat); end
    n_chk++;
    if (wea !== 1) begin n_fail++; $display("FAIL store_wea_cycles: got %0d expected 1", wea); end
    n_chk++;
    if (b1.d_rdata !== 32'd0 || b1.i_rdata !== 32'h12345678) begin
      n_fail++; $display("FAIL store_no_rdata: got %h %h expected 0 12345678", b1.d_rdata, b1.i_rdata);
    end
    n_chk++;
    if (b1.ram_dina !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL store_dina_hold: got %h expected deadbeef", b1.ram_dina);
    end
    run_access(1'b1, 1'b0, 11'h7FF, 32'h0, lat, wea, both);
    n_chk++;
    if (lat !== 3 || wea !== 0) begin
      n_fail++; $display("FAIL load_timing: lat %0d wea %0d expected 3 0", lat, wea);
    end
    n_chk++;
    if (b1.d_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load_rdata: got %h expected deadbeef", b1.d_rdata);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] got;
    logic [3:0] exp_order;
    int         t_ack [4];
    int         n_ack, both, gap_bad;
`ifdef MEM_ARB_RR_EN
    exp_order = 4'b0101;
`else
    exp_order = 4'b1111;
`endif
    got = 4'b0; n_ack = 0; both = 0; gap_bad = 0;
    rst = 1'b1; #2; rst = 1'b0;
    @(posedge clka); #1;
    b1.i_req = 1'b1; b1.i_addr = 11'd5;
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 11'h7FF;
    for (int k = 1; k <= 40 && n_ack < 4; k++) begin
      @(posedge clka); #1;
      if (b1.i_ack && b1.d_ack) both++;
      if (b1.i_ack || b1.d_ack) begin
        got[n_ack] = b1.d_ack;
        t_ack[n_ack] = k;
        n_ack++;
      end
    end
    b1.i_req = 1'b0; b1.d_req = 1'b0;
    for (int j = 1; j < n_ack; j++) if (t_ack[j] - t_ack[j-1] != 4) gap_bad++;
    n_chk++;
    if (n_ack !== 4 || got !== exp_order) begin
      n_fail++; $display("FAIL arb_order: got %0d acks order %b expected 4 acks order %b", n_ack, got, exp_order);
    end
    n_chk++;
    if (both !== 0 || gap_bad !== 0) begin
      n_fail++; $display("FAIL arb_spacing: both %0d bad gaps %0d expected 0 0", both, gap_bad);
    end
    repeat (2) @(posedge clka);
    #1;
  endtask

  task automatic test_reset_abort;
    int acks;
    acks = 0;
    b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 11'd3; b1.d_wdata = 32'hCAFEF00D;
    @(posedge clka); #1;
    n_chk++;
    if (b1.busy !== 1'b1 || b1.ram_wea !== 1'b1) begin
      n_fail++; $display("FAIL abort_issue: busy %b wea %b expected 1 1", b1.busy, b1.ram_wea);
    end
    @(posedge clka); #1;
    b1.d_req = 1'b0; b1.d_we = 1'b0;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({b1.busy, b1.ram_wea, b1.d_ack, b1.i_ack} !== 4'b0000 || b1.ram_addra !== 11'd0) begin
      n_fail++; $display("FAIL abort_async: busy/wea/dack/iack %b addr %h expected 0000 000",
                         {b1.busy, b1.ram_wea, b1.d_ack, b1.i_ack}, b1.ram_addra);
    end
    @(posedge clka); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clka); #1;
      if (b1.d_ack || b1.i_ack || b1.busy) acks++;
    end
    n_chk++;
    if (acks !== 0) begin n_fail++; $display("FAIL abort_no_ack: got %0d events expected 0", acks); end
  endtask

  task automatic test_lat3;
    int lat, busy_low, ack_cnt;
    logic busy_after;
    lat = 0; busy_low = 0; ack_cnt = 0; busy_after = 1'b1;
    b3.i_req = 1'b1; b3.i_addr = 11'd5;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clka); #1;
      if (k == 1) b3.i_addr = 11'd9;
      if (k <= 5 && !b3.busy) busy_low++;
      if (k == 6) busy_after = b3.busy;
      if (b3.i_ack || b3.d_ack) ack_cnt++;
      if (b3.i_ack && lat == 0) begin
        lat = k;
        b3.i_req = 1'b0;
      end
    end
    n_chk++;
    if (lat !== 5 || ack_cnt !== 1) begin
      n_fail++; $display("FAIL lat3_ack: at %0d count %0d expected 5 1", lat, ack_cnt);
    end
    n_chk++;
    if (busy_low !== 0 || busy_after !== 1'b0) begin
      n_fail++; $display("FAIL lat3_busy: low cycles %0d after %b expected 0 0", busy_low, busy_after);
    end
    n_chk++;
    if (b3.i_rdata !== 32'h12345678) begin
      n_fail++; $display("FAIL lat3_rdata: got %h expected 12345678", b3.i_rdata);
    end
  endtask

  initial begin
    rst = 1'b1;
    pre_en = 1'b0; pre_a = '0; pre_d = '0;
    b1.i_req = 1'b0; b1.i_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
    b3.i_req = 1'b0; b3.i_addr = '0; b3.d_req = 1'b0; b3.d_we = 1'b0; b3.d_addr = '0; b3.d_wdata = '0;
    preload(11'd5,   32'h12345678);
    preload(11'd9,   32'h55AA55AA);
    preload(11'h7FA, 32'hFFFF0000);
    test_reset;
    test_fetch;
    test_store_load;
    test_back_to_back;
    test_reset_abort;
    test_lat3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
